branch_recovery_queue: RTL

BRANCH_RECOVERY_QUEUE -- requirements
Module: branch_recovery_queue

---
 rtl/branch_recovery_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/branch_recovery_queue.sv
// branch_recovery_queue
//   Tracks in-flight predicted conditional branches in fetch order and, when
//   execute resolves the oldest one against its prediction, either retires it
//   or flushes the whole queue and issues a one-cycle fetch redirect.
//
//   Parameters
//     OPTION_OPERAND_WIDTH  PC / target width (default 32, must exceed 13)
//     DEPTH                 entries, power of two in 2..16 (default 4)
//
//   Ports
//     clk                    rising-edge clock
//     rst                    synchronous active-low reset
//     push_i                 fetch issues a predicted conditional branch
//     push_pc_i              PC of the pushed branch
//     push_offset_i          signed 13-bit B-type byte offset
//     push_predicted_flag_i  predictor decision for the pushed branch
//     resolve_i              execute resolves the oldest branch
//     flag_i                 actual outcome, valid with resolve_i
//     predicted_flag_o       head prediction, 0 when empty
//     redirect_o             registered one-cycle redirect pulse
//     redirect_pc_o          correct fetch PC, held between redirects
//     full_o / empty_o       occupancy flags
//     count_o                current occupancy
//
//   Optional feature: define BRQ_MISPREDICT_STATS_EN to add the 32-bit
//   mispredict_count_o output (wrapping mispredict counter).
module branch_recovery_queue #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_pc_i,
  input  logic [12:0]                     push_offset_i,
  input  logic                            push_predicted_flag_i,
  input  logic                            resolve_i,
  input  logic                            flag_i,
  output logic                            predicted_flag_o,
  output logic                            redirect_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o
`ifdef BRQ_MISPREDICT_STATS_EN
  ,
  output logic [31:0]                     mispredict_count_o
`endif
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  // Entry storage (no reset needed; validity is tracked by count)
  logic [W-1:0]  pc_mem   [DEPTH];
  logic [12:0]   off_mem  [DEPTH];
  logic          pred_mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             redirect_q, redirect_d;
  logic [W-1:0]     redirect_pc_q, redirect_pc_d;

  logic         empty;
  logic         head_pred;
  logic [W-1:0] head_pc;
  logic [W-1:0] head_off_sext;
  logic         do_resolve;
  logic         mispredict;
  logic         correct;
  logic         push_ok;

  assign empty         = (count_q == '0);
  assign head_pred     = pred_mem[rd_ptr_q];
  assign head_pc       = pc_mem[rd_ptr_q];
  assign head_off_sext = {{(W-13){off_mem[rd_ptr_q][12]}}, off_mem[rd_ptr_q]};

  assign do_resolve = (state_q == NORMAL) && resolve_i && !empty;
  assign mispredict = do_resolve && (flag_i != head_pred);
  assign correct    = do_resolve && (flag_i == head_pred);
  // A full queue still accepts a push when the head retires in the same cycle.
  assign push_ok    = (state_q == NORMAL) && push_i && !mispredict &&
                      ((count_q < DEPTH_C) || correct);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (state_q == RECOVER) begin
      state_d = NORMAL;
    end else if (mispredict) begin
      state_d       = RECOVER;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      redirect_d    = 1'b1;
      redirect_pc_d = flag_i ? (head_pc + head_off_sext) : (head_pc + W'(4));
    end else begin
      if (correct) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push_ok && !correct) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && correct) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= NORMAL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      pc_mem[wr_ptr_q]   <= push_pc_i;
      off_mem[wr_ptr_q]  <= push_offset_i;
      pred_mem[wr_ptr_q] <= push_predicted_flag_i;
    end
  end

`ifdef BRQ_MISPREDICT_STATS_EN
  logic [31:0] mispredict_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mispredict_cnt_q <= '0;
    end else if (mispredict) begin
      mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign mispredict_count_o = mispredict_cnt_q;
`endif

  assign predicted_flag_o = empty ? 1'b0 : head_pred;
  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign full_o           = (count_q == DEPTH_C);
  assign empty_o          = empty;
  assign count_o          = count_q;

endmodule
